// File: rtl/cla_digit_serial_adder.sv
// Digit-serial WIDTH-bit adder: one 4-bit carry-lookahead slice processes
// one digit per cycle, LSB digit first, with the slice carry-out registered
// and fed back as the next digit's carry-in. Valid/ready on both sides.
module cla_digit_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             a_msb;
    logic             b_msb;
    logic             cout_r;
    logic             ovf_r;

    // Slice signals
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    logic [3:0] s4;
    logic       c4;
    logic       grp_g;
    logic       grp_p;

    // 4-bit carry-lookahead slice on the current low digit and the carry register
    always_comb begin
        g     = a_sh[3:0] & b_sh[3:0];
        p     = a_sh[3:0] ^ b_sh[3:0];
        c[0]  = carry;
        c[1]  = g[0] | (p[0] & carry);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & carry);
        grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
        grp_p = &p;
        c4    = grp_g | (grp_p & carry);
        s4    = p ^ c;
    end

    // Control FSM plus operand, sum and flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_sh <= {s4, sum_sh[WIDTH-1:4]};
                    a_sh   <= {4'b0000, a_sh[WIDTH-1:4]};
                    b_sh   <= {4'b0000, b_sh[WIDTH-1:4]};
                    carry  <= c4;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        cout_r <= c4;
                        ovf_r  <= (a_msb == b_msb) & (s4[3] != a_msb);
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_sh;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_cla_digit_serial_adder.sv
// Self-checking bench for cla_digit_serial_adder at WIDTH=16.
module tb_cla_digit_serial_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int checks;
    int errors;

    cla_digit_serial_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait for IDLE, present one operand set, then wait (bounded) for out_valid.
    // Leaves the result pending in DONE with out_ready low.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                         output logic [15:0] s, output logic co, output logic ov,
                         output int lat);
        int n;
        n = 0;
        out_ready = 1'b0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = ~ta; b = ~tb_v; cin = ~tc;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        s = sum; co = cout; ov = ovf;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b required 1 0 0000 0 0",
                     in_ready, out_valid, sum, cout, ovf);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_exit: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b required 1 0 0000 0 0",
                     in_ready, out_valid, sum, cout, ovf);
        end
    endtask

    task automatic test_vectors();
        logic [15:0] va [6] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h1234, 16'hFFFF, 16'h0000};
        logic [15:0] vb [6] = '{16'h0001, 16'h0001, 16'h8000, 16'h4321, 16'hFFFF, 16'h0000};
        logic        vc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [15:0] es [6] = '{16'h0000, 16'h8000, 16'h0000, 16'h5556, 16'hFFFF, 16'h0001};
        logic        ec [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic        eo [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [15:0] s;
        logic        co;
        logic        ov;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            do_op(va[i], vb[i], vc[i], s, co, ov, lat);
            checks++;
            if (lat !== 4) begin
                errors++;
                $display("FAIL vec%0d_latency: got %0d negedges after accept, required 4", i, lat);
            end
            checks++;
            if (s !== es[i] || co !== ec[i] || ov !== eo[i]) begin
                errors++;
                $display("FAIL vec%0d_result: %h+%h+%b got sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                         i, va[i], vb[i], vc[i], s, co, ov, es[i], ec[i], eo[i]);
            end
            release_result();
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL vec%0d_handshake: in_ready=%b out_valid=%b required 1 0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_stall();
        logic [15:0] s;
        logic        co;
        logic        ov;
        int          lat;
        int          spurious;
        do_op(16'h2222, 16'h1111, 1'b0, s, co, ov, lat);
        checks++;
        if (s !== 16'h3333 || co !== 1'b0 || ov !== 1'b0) begin
            errors++;
            $display("FAIL stall_result: sum=%h cout=%b ovf=%b required 3333 0 0", s, co, ov);
        end
        for (int k = 0; k < 3; k++) begin
            a = 16'h0F0F; b = 16'h1234; cin = 1'b1; in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 16'h3333 || cout !== 1'b0 || ovf !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: out_valid=%b in_ready=%b sum=%h cout=%b ovf=%b required 1 0 3333 0 0",
                         k, out_valid, in_ready, sum, cout, ovf);
            end
        end
        release_result();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        spurious = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) spurious++;
        end
        checks++;
        if (spurious !== 0) begin
            errors++;
            $display("FAIL stall_ignored_pulses: out_valid seen %0d cycles, required 0", spurious);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] va [5] = '{16'h0003, 16'h00FF, 16'hF000, 16'h4000, 16'hABCD};
        logic [15:0] vb [5] = '{16'h0004, 16'h0001, 16'h1000, 16'h4000, 16'h1111};
        logic        vc [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [15:0] es [5] = '{16'h0007, 16'h0100, 16'h0000, 16'h8000, 16'hBCDF};
        logic        ec [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        eo [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int sent;
        int got;
        int cyc;
        int last;
        sent = 0; got = 0; cyc = 0; last = -1;
        out_ready = 1'b1;
        while (got < 5 && cyc < 100) begin
            if (out_valid) begin
                checks++;
                if (sum !== es[got] || cout !== ec[got] || ovf !== eo[got]) begin
                    errors++;
                    $display("FAIL b2b_result%0d: sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                             got, sum, cout, ovf, es[got], ec[got], eo[got]);
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last !== 6) begin
                        errors++;
                        $display("FAIL b2b_period%0d: got %0d cycles, required 6", got, cyc - last);
                    end
                end
                last = cyc;
                got++;
            end
            if (in_ready) begin
                if (sent < 5) begin
                    a = va[sent]; b = vb[sent]; cin = vc[sent]; in_valid = 1'b1;
                    sent++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (got !== 5) begin
            errors++;
            $display("FAIL b2b_count: got %0d results, required 5", got);
        end
        repeat (8) begin
            @(negedge clk);
            if (out_valid) got++;
        end
        checks++;
        if (got !== 5) begin
            errors++;
            $display("FAIL b2b_duplicate: got %0d results total, required 5", got);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] s;
        logic        co;
        logic        ov;
        int          lat;
        int          spurious;
        a = 16'h5555; b = 16'h5555; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b required 1 0 0000 0 0",
                     in_ready, out_valid, sum, cout, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid || !in_ready) spurious++;
        end
        checks++;
        if (spurious !== 0) begin
            errors++;
            $display("FAIL midrun_no_result: busy/valid seen %0d cycles, required 0", spurious);
        end
        do_op(16'h0001, 16'h0001, 1'b0, s, co, ov, lat);
        checks++;
        if (lat !== 4 || s !== 16'h0002 || co !== 1'b0 || ov !== 1'b0) begin
            errors++;
            $display("FAIL midrun_next_op: lat=%0d sum=%h cout=%b ovf=%b required 4 0002 0 0", lat, s, co, ov);
        end
        release_result();
    endtask

    task automatic test_random();
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic [16:0] full;
        logic        eov;
        logic [15:0] s;
        logic        co;
        logic        ov;
        int          lat;
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            full = {1'b0, ra} + {1'b0, rb} + {16'h0000, rc};
            eov = (ra[15] == rb[15]) && (full[15] != ra[15]);
            do_op(ra, rb, rc, s, co, ov, lat);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            checks++;
            if (lat !== 4 || out_valid !== 1'b1 || sum !== full[15:0] || cout !== full[16] || ovf !== eov) begin
                errors++;
                $display("FAIL rand%0d: %h+%h+%b lat=%0d valid=%b sum=%h cout=%b ovf=%b required 4 1 %h %b %b",
                         i, ra, rb, rc, lat, out_valid, sum, cout, ovf, full[15:0], full[16], eov);
            end
            release_result();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_vectors();
        test_stall();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
